// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with showahead or registered read, occupancy flags
// and one-cycle overflow/underflow pulses.
module fifo_sync #(
    parameter int SHOWAHEAD = 1,
    parameter int ABITS     = 10,
    parameter int DBITS     = 16,
    parameter int FTHR      = 800,
    parameter int ETHR      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DBITS-1:0] wr_data,
    input  logic             wr_en,
    output logic             wr_full,
    output logic             almost_full,
    output logic             overflow,
    input  logic             rd_en,
    output logic [DBITS-1:0] rd_data,
    output logic             rd_empty,
    output logic             almost_empty,
    output logic             underflow,
    output logic [ABITS:0]   data_count
);
    localparam int DEPTH = 2 ** ABITS;
    localparam logic [ABITS:0] CNT_FULL = (ABITS+1)'(DEPTH);
    localparam logic [ABITS:0] CNT_AF   = (ABITS+1)'(FTHR);
    localparam logic [ABITS:0] CNT_AE   = (ABITS+1)'(ETHR);

    if (FTHR < 1 || FTHR > DEPTH) begin : g_bad_fthr
        $error("fifo_sync: FTHR out of range");
    end
    if (ETHR < 0 || ETHR >= FTHR) begin : g_bad_ethr
        $error("fifo_sync: ETHR out of range");
    end

    logic [DBITS-1:0] mem [DEPTH];
    logic [ABITS-1:0] wr_ptr;
    logic [ABITS-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;
    logic [ABITS:0]   cnt_n;

    always_comb begin
        wr_ok = wr_en && !wr_full;
        rd_ok = rd_en && !rd_empty;
        cnt_n = data_count + (ABITS+1)'(wr_ok) - (ABITS+1)'(rd_ok);
    end

    // Flags are registered from the next count so they stay aligned with data_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            data_count   <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            rd_empty     <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr + ABITS'(wr_ok);
            rd_ptr       <= rd_ptr + ABITS'(rd_ok);
            data_count   <= cnt_n;
            wr_full      <= cnt_n == CNT_FULL;
            almost_full  <= cnt_n >= CNT_AF;
            rd_empty     <= cnt_n == '0;
            almost_empty <= cnt_n <= CNT_AE;
            overflow     <= wr_en && wr_full;
            underflow    <= rd_en && rd_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[wr_ptr] <= wr_data;
    end

    if (SHOWAHEAD != 0) begin : g_showahead
        assign rd_data = rd_empty ? '0 : mem[rd_ptr];
    end else begin : g_normal
        always_ff @(posedge clk) begin
            if (rst) rd_data <= '0;
            else if (rd_ok) rd_data <= mem[rd_ptr];
        end
    end
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed checks of fifo_sync (depth 4) in showahead and normal read modes.
module tb_fifo_sync;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       wr_full, almost_full, overflow, rd_empty, almost_empty, underflow;
    logic [7:0] rd_data;
    logic [2:0] data_count;
    logic       n_wr_full, n_almost_full, n_overflow, n_rd_empty, n_almost_empty, n_underflow;
    logic [7:0] n_rd_data;
    logic [2:0] n_data_count;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_sync #(.SHOWAHEAD(1), .ABITS(2), .DBITS(8), .FTHR(3), .ETHR(1)) u_sa (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
        .almost_full(almost_full), .overflow(overflow), .rd_en(rd_en), .rd_data(rd_data),
        .rd_empty(rd_empty), .almost_empty(almost_empty), .underflow(underflow),
        .data_count(data_count)
    );

    fifo_sync #(.SHOWAHEAD(0), .ABITS(2), .DBITS(8), .FTHR(3), .ETHR(1)) u_norm (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(n_wr_full),
        .almost_full(n_almost_full), .overflow(n_overflow), .rd_en(rd_en), .rd_data(n_rd_data),
        .rd_empty(n_rd_empty), .almost_empty(n_almost_empty), .underflow(n_underflow),
        .data_count(n_data_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++; if (data_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", data_count); end
        checks++; if ({rd_empty, almost_empty, wr_full, almost_full} !== 4'b1100) begin errors++; $display("FAIL reset_flags got=%b exp=1100", {rd_empty, almost_empty, wr_full, almost_full}); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {overflow, underflow}); end
        checks++; if (rd_data !== 8'h00 || n_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h/%h exp=00/00", rd_data, n_rd_data); end
        checks++; if (n_data_count !== 3'd0 || n_rd_empty !== 1'b1) begin errors++; $display("FAIL reset_norm got=%0d/%b exp=0/1", n_data_count, n_rd_empty); end
    endtask

    task automatic test_fill();
        logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [3:0] exp_ae = 4'b0001;
        logic [3:0] exp_af = 4'b1100;
        logic [3:0] exp_fu = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            wr_data = d[i]; wr_en = 1'b1;
            step();
            checks++; if (data_count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, data_count, i + 1); end
            checks++; if ({almost_empty, almost_full, wr_full, rd_empty} !== {exp_ae[i], exp_af[i], exp_fu[i], 1'b0}) begin errors++; $display("FAIL fill_flags[%0d] got=%b exp=%b", i, {almost_empty, almost_full, wr_full, rd_empty}, {exp_ae[i], exp_af[i], exp_fu[i], 1'b0}); end
            checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL fill_head[%0d] got=%h exp=11", i, rd_data); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        wr_data = 8'h55; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1 || n_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b/%b exp=1/1", overflow, n_overflow); end
        checks++; if (data_count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", data_count); end
        step();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_data !== d[i]) begin errors++; $display("FAIL ovf_sa_rd[%0d] got=%h exp=%h", i, rd_data, d[i]); end
            rd_en = 1'b1;
            step();
            checks++; if (n_rd_data !== d[i]) begin errors++; $display("FAIL ovf_norm_rd[%0d] got=%h exp=%h", i, n_rd_data, d[i]); end
            checks++; if (data_count !== 3'(3 - i)) begin errors++; $display("FAIL ovf_drain_count[%0d] got=%0d exp=%0d", i, data_count, 3 - i); end
        end
        rd_en = 1'b0;
        checks++; if (rd_empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got=%b%b exp=11", rd_empty, almost_empty); end
        step();
        checks++; if (n_rd_data !== 8'h44) begin errors++; $display("FAIL norm_hold got=%h exp=44", n_rd_data); end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'hA5;
        step();
        rd_en = 1'b0; wr_en = 1'b0;
        checks++; if (underflow !== 1'b1 || n_underflow !== 1'b1) begin errors++; $display("FAIL udf_pulse got=%b/%b exp=1/1", underflow, n_underflow); end
        checks++; if (data_count !== 3'd1 || rd_empty !== 1'b0) begin errors++; $display("FAIL udf_count got=%0d/%b exp=1/0", data_count, rd_empty); end
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL udf_sa_rd got=%h exp=a5", rd_data); end
        checks++; if (n_rd_data !== 8'h44) begin errors++; $display("FAIL udf_norm_hold got=%h exp=44", n_rd_data); end
        step();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_clear got=%b exp=0", underflow); end
    endtask

    task automatic test_full_rdwr();
        logic [7:0] d [3] = '{8'hB1, 8'hB2, 8'hB3};
        for (int i = 0; i < 3; i++) begin
            wr_data = d[i]; wr_en = 1'b1;
            step();
        end
        checks++; if (wr_full !== 1'b1 || data_count !== 3'd4) begin errors++; $display("FAIL frw_full got=%b/%0d exp=1/4", wr_full, data_count); end
        wr_data = 8'hC4; wr_en = 1'b1; rd_en = 1'b1;
        step();
        wr_en = 1'b0;
        checks++; if (data_count !== 3'd3 || overflow !== 1'b1) begin errors++; $display("FAIL frw_count_ovf got=%0d/%b exp=3/1", data_count, overflow); end
        checks++; if (n_rd_data !== 8'hA5 || rd_data !== 8'hB1) begin errors++; $display("FAIL frw_rd got=%h/%h exp=a5/b1", n_rd_data, rd_data); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd_data !== d[i]) begin errors++; $display("FAIL frw_drain[%0d] got=%h exp=%h", i, rd_data, d[i]); end
            step();
        end
        rd_en = 1'b0;
        checks++; if (data_count !== 3'd0 || n_rd_data !== 8'hB3) begin errors++; $display("FAIL frw_end got=%0d/%h exp=0/b3", data_count, n_rd_data); end
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1;
        wr_data = 8'h01; step();
        wr_data = 8'h02; step();
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (rd_data !== 8'(i + 1)) begin errors++; $display("FAIL wrap_sa[%0d] got=%h exp=%h", i, rd_data, 8'(i + 1)); end
            wr_data = 8'(i + 3);
            step();
            checks++; if (data_count !== 3'd2 || n_rd_data !== 8'(i + 1)) begin errors++; $display("FAIL wrap_cnt_norm[%0d] got=%0d/%h exp=2/%h", i, data_count, n_rd_data, 8'(i + 1)); end
        end
        wr_en = 1'b0;
        step();
        rd_en = 1'b0;
        checks++; if (data_count !== 3'd1 || rd_data !== 8'h0C) begin errors++; $display("FAIL wrap_tail got=%0d/%h exp=1/0c", data_count, rd_data); end
        wr_data = 8'h77; wr_en = 1'b1; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (data_count !== 3'd1 || rd_data !== 8'h77) begin errors++; $display("FAIL sa_count1 got=%0d/%h exp=1/77", data_count, rd_data); end
        checks++; if (n_rd_data !== 8'h0C) begin errors++; $display("FAIL norm_count1 got=%h exp=0c", n_rd_data); end
    endtask

    task automatic test_reset_mid();
        wr_en = 1'b1;
        wr_data = 8'h81; step();
        wr_data = 8'h82; step();
        checks++; if (data_count !== 3'd3) begin errors++; $display("FAIL rmid_pre got=%0d exp=3", data_count); end
        rst = 1'b1; rd_en = 1'b1; wr_data = 8'h83;
        step();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (data_count !== 3'd0 || rd_empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("FAIL rmid_state got=%0d/%b%b exp=0/11", data_count, rd_empty, almost_empty); end
        checks++; if (rd_data !== 8'h00 || n_rd_data !== 8'h00) begin errors++; $display("FAIL rmid_rd got=%h/%h exp=00/00", rd_data, n_rd_data); end
        wr_data = 8'h9C; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        checks++; if (data_count !== 3'd1 || rd_data !== 8'h9C) begin errors++; $display("FAIL rmid_wr got=%0d/%h exp=1/9c", data_count, rd_data); end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++; if (data_count !== 3'd0 || n_rd_data !== 8'h9C) begin errors++; $display("FAIL rmid_rd_new got=%0d/%h exp=0/9c", data_count, n_rd_data); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_full_rdwr();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
